truth_table_sweeper: RTL and testbench

- Self-checking, clocked exhaustive stimulus engine for combinational logic blocks with N_IN inputs and one output.
- On `start` it drives every input vector onto the DUT and holds each for a settle window, then samples the DUT output.
- Each sample is compared against a parameterised expected truth table; the block accumulates the mismatch count and captures the first failing vector.
- It sits in benches and on-board self-test wrappers, next to the combinational block under test.

---
 rtl/truth_table_sweeper.sv | 138 +++++++++++++
 tb/tb_truth_table_sweeper.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/truth_table_sweeper.sv
// Exhaustive clocked stimulus/check engine for an N_IN-input, single-output combinational block.
// Define SWEEP_GRAY_EN to sweep in Gray-code order instead of binary order.
module truth_table_sweeper #(
  parameter int                   N_IN        = 4,
  parameter int                   HOLD_CYCLES = 1,
  parameter logic [(1<<N_IN)-1:0] EXPECT      = 16'h8000
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            abort,
  input  logic            dut_y,
  output logic [N_IN-1:0] vec_out,
  output logic            busy,
  output logic            done,
  output logic            pass,
  output logic [N_IN:0]   err_count,
  output logic [N_IN-1:0] first_err_vec
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_APPLY = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;
  localparam logic [7:0] HOLD_LAST = 8'(HOLD_CYCLES);

  logic [1:0]      state_q, state_d;
  logic [N_IN:0]   idx_q, idx_d;
  logic [7:0]      hold_q, hold_d;
  logic [N_IN-1:0] vec_q, vec_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic [N_IN:0]   err_q, err_d;
  logic [N_IN-1:0] first_q, first_d;

  logic [N_IN:0]   idx_inc;
  logic [N_IN-1:0] vec_inc;
  logic            mismatch;

  // The spare top index bit flags the step past the last vector instead of wrapping to 0.
  assign idx_inc = idx_q + 1'b1;

  for (genvar gi = 0; gi < N_IN; gi++) begin : g_map
`ifdef SWEEP_GRAY_EN
    assign vec_inc[gi] = idx_inc[gi] ^ idx_inc[gi+1];
`else
    assign vec_inc[gi] = idx_inc[gi];
`endif
  end

  assign mismatch = (dut_y != EXPECT[vec_q]);

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    hold_d  = hold_q;
    vec_d   = vec_q;
    busy_d  = busy_q;
    done_d  = done_q;
    err_d   = err_q;
    first_d = first_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d = S_APPLY;
          idx_d   = '0;
          hold_d  = '0;
          vec_d   = '0;
          busy_d  = 1'b1;
          done_d  = 1'b0;
          err_d   = '0;
          first_d = '0;
        end
      end
      S_APPLY: begin
        if (abort) begin
          // Partial error results are deliberately kept for post-mortem.
          state_d = S_IDLE;
          idx_d   = '0;
          hold_d  = '0;
          vec_d   = '0;
          busy_d  = 1'b0;
          done_d  = 1'b0;
        end else if (hold_q != HOLD_LAST) begin
          hold_d = hold_q + 8'd1;
        end else begin
          if (mismatch) begin
            err_d = err_q + 1'b1;
            if (err_q == '0) first_d = vec_q;
          end
          if (idx_inc[N_IN]) begin
            state_d = S_DONE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            idx_d  = idx_inc;
            vec_d  = vec_inc;
            hold_d = '0;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
        done_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      hold_q  <= '0;
      vec_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= '0;
      first_q <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      hold_q  <= hold_d;
      vec_q   <= vec_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
      first_q <= first_d;
    end
  end

  assign vec_out       = vec_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign pass          = done_q && (err_q == '0);
  assign err_count     = err_q;
  assign first_err_vec = first_q;

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Directed bench for truth_table_sweeper: a default instance plus two N_IN=3, HOLD_CYCLES=0 instances.
module tb_truth_table_sweeper;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int mode   = 0;

  logic       rst, start, abort, dut_y;
  logic [3:0] vec;
  logic       busy, done, pass;
  logic [4:0] errc;
  logic [3:0] fev;

  logic       start3, dut_y3, dut_y6;
  logic [2:0] vec3, vec6;
  logic       busy3, done3, pass3, busy6, done6, pass6;
  logic [3:0] errc3, errc6;
  logic [2:0] fev3, fev6;

  // mode 0: AND, 1: OR, 2: constant 0, 3: high only on vector 4
  assign dut_y  = (mode == 0) ? &vec : (mode == 1) ? |vec : (mode == 2) ? 1'b0 : (vec == 4'd4);
  assign dut_y3 = ^vec3;
  assign dut_y6 = 1'b1;

  truth_table_sweeper u_dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .dut_y(dut_y),
    .vec_out(vec), .busy(busy), .done(done), .pass(pass),
    .err_count(errc), .first_err_vec(fev)
  );

  truth_table_sweeper #(.N_IN(3), .HOLD_CYCLES(0), .EXPECT(8'h96)) u_dut3 (
    .clk(clk), .rst(rst), .start(start3), .abort(1'b0), .dut_y(dut_y3),
    .vec_out(vec3), .busy(busy3), .done(done3), .pass(pass3),
    .err_count(errc3), .first_err_vec(fev3)
  );

  truth_table_sweeper #(.N_IN(3), .HOLD_CYCLES(0), .EXPECT(8'h00)) u_dut6 (
    .clk(clk), .rst(rst), .start(start3), .abort(1'b0), .dut_y(dut_y6),
    .vec_out(vec6), .busy(busy6), .done(done6), .pass(pass6),
    .err_count(errc6), .first_err_vec(fev6)
  );

  function automatic int gmap(int i);
`ifdef SWEEP_GRAY_EN
    return i ^ (i >> 1);
`else
    return i;
`endif
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; abort = 1'b0; start3 = 1'b0; mode = 0;
    step(); step();
    rst = 1'b0;
    check("rst_vec", 32'(vec), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_pass", 32'(pass), 0);
    check("rst_err", 32'(errc), 0);
    check("rst_fev", 32'(fev), 0);
    check("rst_busy3", 32'(busy3), 0);
    $display("reset: outputs checked");

    // Test 1: AND against default AND table, each vector held 2 cycles
    mode = 0; start = 1'b1; step(); start = 1'b0;
    for (int j = 0; j < 32; j++) begin
      check("t1_vec", 32'(vec), 32'(gmap(j / 2)));
      check("t1_busy", 32'(busy), 1);
      check("t1_done", 32'(done), 0);
      step();
    end
    check("t1_done_end", 32'(done), 1);
    check("t1_busy_end", 32'(busy), 0);
    check("t1_pass", 32'(pass), 1);
    check("t1_err", 32'(errc), 0);
    check("t1_vec_last", 32'(vec), 32'(gmap(15)));
    $display("test1: AND sweep done=%0d pass=%0d err=%0d", done, pass, errc);

    // Test 2: OR against AND table -> 14 mismatches, first at vector 1
    mode = 1; start = 1'b1; step(); start = 1'b0;
    check("t2_busy", 32'(busy), 1);
    check("t2_done_clr", 32'(done), 0);
    repeat (31) step();
    check("t2_done_early", 32'(done), 0);
    step();
    check("t2_done", 32'(done), 1);
    check("t2_err", 32'(errc), 14);
    check("t2_fev", 32'(fev), 1);
    check("t2_pass", 32'(pass), 0);
    $display("test2: OR sweep err=%0d first=%0d pass=%0d", errc, fev, pass);

    // Test 3 / 6: parity table (pass) and all-zero table with dut_y=1 (8 errors)
    start3 = 1'b1; step(); start3 = 1'b0;
    for (int j = 0; j < 8; j++) begin
      check("t3_vec", 32'(vec3), 32'(gmap(j)));
      check("t3_busy", 32'(busy3), 1);
      check("t6_vec", 32'(vec6), 32'(gmap(j)));
      step();
    end
    check("t3_done", 32'(done3), 1);
    check("t3_pass", 32'(pass3), 1);
    check("t3_err", 32'(errc3), 0);
    check("t6_err", 32'(errc6), 8);
    check("t6_fev", 32'(fev6), 0);
    check("t6_pass", 32'(pass6), 0);
    check("t6_done", 32'(done6), 1);
    start3 = 1'b1; step(); start3 = 1'b0;
    check("t3r_done_clr", 32'(done3), 0);
    check("t3r_busy", 32'(busy3), 1);
    check("t3r_vec", 32'(vec3), 0);
    check("t6r_err_clr", 32'(errc6), 0);
    repeat (7) step();
    check("t3r_done_early", 32'(done3), 0);
    step();
    check("t3r_done", 32'(done3), 1);
    check("t3r_pass", 32'(pass3), 1);
    check("t6r_err", 32'(errc6), 8);
    $display("test3/6: parity pass=%0d, zero-table err=%0d", pass3, errc6);

    // Test 4: restart from DONE clears errors; start mid-sweep ignored; abort wins over start
    mode = 2; start = 1'b1; step(); start = 1'b0;
    check("t4_err_clr", 32'(errc), 0);
    check("t4_fev_clr", 32'(fev), 0);
    check("t4_done_clr", 32'(done), 0);
    check("t4_busy", 32'(busy), 1);
    repeat (6) step();
    check("t4_vec3", 32'(vec), 32'(gmap(3)));
    start = 1'b1; step(); start = 1'b0;
    check("t4_norestart", 32'(vec), 32'(gmap(3)));
    step();
    check("t4_vec4", 32'(vec), 32'(gmap(4)));
    step(); step();
    check("t4_vec5", 32'(vec), 32'(gmap(5)));
    abort = 1'b1; start = 1'b1; step(); abort = 1'b0; start = 1'b0;
    check("t4_abort_busy", 32'(busy), 0);
    check("t4_abort_done", 32'(done), 0);
    check("t4_abort_vec", 32'(vec), 0);
    check("t4_abort_err", 32'(errc), 0);
    abort = 1'b1; step(); abort = 1'b0;
    check("t4_idle_abort", 32'(busy), 0);
    abort = 1'b1; start = 1'b1; step(); abort = 1'b0; start = 1'b0;
    check("t4_idle_start", 32'(busy), 1);
    check("t4_idle_vec", 32'(vec), 0);
    repeat (32) step();
    check("t4_done", 32'(done), 1);
    check("t4_err", 32'(errc), 1);
    check("t4_fev", 32'(fev), 15);
    $display("test4: abort/start ordering, final err=%0d first=%0d", errc, fev);

    // Test 5: reset mid-sweep, then a clean sweep
    mode = 3; start = 1'b1; step(); start = 1'b0;
    repeat (18) step();
    check("t5_vec9", 32'(vec), 32'(gmap(9)));
    check("t5_err1", 32'(errc), 1);
    check("t5_fev4", 32'(fev), 4);
    rst = 1'b1; step(); rst = 1'b0;
    check("t5_rst_vec", 32'(vec), 0);
    check("t5_rst_busy", 32'(busy), 0);
    check("t5_rst_err", 32'(errc), 0);
    check("t5_rst_fev", 32'(fev), 0);
    check("t5_rst_done", 32'(done), 0);
    step();
    check("t5_idle", 32'(busy), 0);
    mode = 0; start = 1'b1; step(); start = 1'b0;
    repeat (31) step();
    check("t5_done_early", 32'(done), 0);
    check("t5_busy_late", 32'(busy), 1);
    step();
    check("t5_done", 32'(done), 1);
    check("t5_pass", 32'(pass), 1);
    check("t5_err", 32'(errc), 0);
    $display("test5: post-reset sweep pass=%0d", pass);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
